// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_cfg
// Brief   : UART transmitter with runtime baud divider, parity, 1/2 stop
//           bits and an input FIFO; frames go out back-to-back.
// Revision: 1.0
// ============================================================================
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          stop2,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0]       r_count;

  state_t                r_state, w_state_nxt;
  logic [DIV_WIDTH-1:0]  r_timer, w_timer_nxt;
  logic [DIV_WIDTH-1:0]  r_div, w_div_nxt;
  logic [c_BW-1:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic                  r_stop_cnt, w_stop_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  r_par_en, w_par_en_nxt;
  logic                  r_par_bit, w_par_bit_nxt;
  logic                  r_stop2, w_stop2_nxt;
  logic                  r_tx, w_tx_nxt;

  logic                  w_push, w_pop, w_load, w_bit_end;
  logic [DATA_WIDTH-1:0] w_head;
  logic [DIV_WIDTH-1:0]  w_div_clamp;

  assign s_ready     = (r_count != c_CW'(FIFO_DEPTH));
  assign w_push      = s_valid && s_ready;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_div_clamp = (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : baud_div;
  assign w_bit_end   = (r_timer == r_div - DIV_WIDTH'(1));

  assign tx         = r_tx;
  assign fifo_count = r_count;
  assign tx_busy    = (r_state != S_IDLE) || (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_div      <= DIV_WIDTH'(2);
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_div      <= w_div_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_par_en   <= w_par_en_nxt;
      r_par_bit  <= w_par_bit_nxt;
      r_stop2    <= w_stop2_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer + DIV_WIDTH'(1);
    w_div_nxt      = r_div;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_shift_nxt    = r_shift;
    w_par_en_nxt   = r_par_en;
    w_par_bit_nxt  = r_par_bit;
    w_stop2_nxt    = r_stop2;
    w_tx_nxt       = r_tx;
    w_load         = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        w_tx_nxt    = 1'b1;
        if (r_count != '0) w_load = 1'b1;
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt   = S_DATA;
          w_timer_nxt   = '0;
          w_bit_cnt_nxt = '0;
          w_tx_nxt      = r_shift[0];
          w_shift_nxt   = r_shift >> 1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_timer_nxt = '0;
          if (r_bit_cnt == c_BW'(DATA_WIDTH - 1)) begin
            w_stop_cnt_nxt = 1'b0;
            if (r_par_en) begin
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_par_bit;
            end else begin
              w_state_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + c_BW'(1);
            w_tx_nxt      = r_shift[0];
            w_shift_nxt   = r_shift >> 1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt    = S_STOP;
          w_timer_nxt    = '0;
          w_stop_cnt_nxt = 1'b0;
          w_tx_nxt       = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_timer_nxt = '0;
          if (r_stop2 && !r_stop_cnt) begin
            w_stop_cnt_nxt = 1'b1;
          end else if (r_count != '0) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // Frame start: pop the head and snapshot the configuration for this frame.
    if (w_load) begin
      w_state_nxt   = S_START;
      w_timer_nxt   = '0;
      w_tx_nxt      = 1'b0;
      w_shift_nxt   = w_head;
      w_div_nxt     = w_div_clamp;
      w_par_en_nxt  = parity_en;
      w_par_bit_nxt = (^w_head) ^ parity_odd;
      w_stop2_nxt   = stop2;
    end
  end

  assign w_pop = w_load;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_cfg
// Brief   : Directed self-checking bench for uart_tx_cfg.
// Revision: 1.0
// ============================================================================
module tb_uart_tx_cfg;

  logic        clk;
  logic        rstn;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic        stop2;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        tx;
  logic        tx_busy;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  uart_tx_cfg #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    s_data  = d;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  // Call positioned just after the push (or previous frame's last) edge.
  task automatic expect_frame(input logic [7:0] d, input int div,
                              input logic pen, input logic pbit, input logic s2);
    logic bits [13];
    int   nb;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
    nb = 9;
    if (pen) begin bits[nb] = pbit; nb = nb + 1; end
    bits[nb] = 1'b1; nb = nb + 1;
    if (s2) begin bits[nb] = 1'b1; nb = nb + 1; end
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < div; c++) begin
        tick();
        chk($sformatf("tx_bit%0d_clk%0d_d%0h", b, c, d), {31'd0, tx}, {31'd0, bits[b]});
      end
    end
  endtask

  task automatic expect_idle_after();
    tick();
    chk("busy_after_frame", {31'd0, tx_busy}, 32'd0);
    chk("tx_after_frame", {31'd0, tx}, 32'd1);
  endtask

  initial begin
    logic [7:0] words [5];
    logic       saw_low;

    rstn       = 1'b0;
    baud_div   = 16'd4;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;
    s_data     = 8'h00;
    s_valid    = 1'b0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    rstn = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    chk("idle_tx_low_seen", {31'd0, saw_low}, 32'd0);

    // Basic 8N1 frame, div 4
    push_word(8'hA5);
    chk("count_after_push", {29'd0, fifo_count}, 32'd1);
    chk("busy_after_push", {31'd0, tx_busy}, 32'd1);
    expect_frame(8'hA5, 4, 1'b0, 1'b0, 1'b0);
    expect_idle_after();

    // Parity + two stop bits, div 3
    baud_div = 16'd3; parity_en = 1'b1; stop2 = 1'b1;
    parity_odd = 1'b0;
    push_word(8'hA5);
    expect_frame(8'hA5, 3, 1'b1, 1'b0, 1'b1);
    expect_idle_after();
    parity_odd = 1'b1;
    push_word(8'h07);
    expect_frame(8'h07, 3, 1'b1, 1'b0, 1'b1);
    expect_idle_after();
    push_word(8'h03);
    expect_frame(8'h03, 3, 1'b1, 1'b1, 1'b1);
    expect_idle_after();

    // Full FIFO and back-to-back frames, div 2
    baud_div = 16'd2; parity_en = 1'b0; stop2 = 1'b0; parity_odd = 1'b0;
    words[0] = 8'h3C; words[1] = 8'hC3; words[2] = 8'h01;
    words[3] = 8'h80; words[4] = 8'hFF;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          chk($sformatf("ready_before_push%0d", i), {31'd0, s_ready}, 32'd1);
          s_data  = words[i];
          s_valid = 1'b1;
          tick();
        end
        s_valid = 1'b0;
        chk("ready_when_full", {31'd0, s_ready}, 32'd0);
        chk("count_when_full", {29'd0, fifo_count}, 32'd4);
        repeat (16) tick();
        chk("count_before_start1", {29'd0, fifo_count}, 32'd4);
        tick();
        chk("count_at_start1", {29'd0, fifo_count}, 32'd3);
        chk("ready_after_pop", {31'd0, s_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
          repeat (19) tick();
          chk($sformatf("count_before_start%0d", k + 2), {29'd0, fifo_count}, 32'(3 - k));
          tick();
          chk($sformatf("count_at_start%0d", k + 2), {29'd0, fifo_count}, 32'(2 - k));
        end
      end
      begin
        tick();
        for (int i = 0; i < 5; i++) expect_frame(words[i], 2, 1'b0, 1'b0, 1'b0);
      end
    join
    expect_idle_after();

    // Divider clamp
    baud_div = 16'd0;
    push_word(8'h5A);
    expect_frame(8'h5A, 2, 1'b0, 1'b0, 1'b0);
    expect_idle_after();
    baud_div = 16'd1;
    push_word(8'h96);
    expect_frame(8'h96, 2, 1'b0, 1'b0, 1'b0);
    expect_idle_after();

    // Divider change mid-frame applies from next frame
    baud_div = 16'd4;
    fork
      begin
        push_word(8'h69);
        push_word(8'hB4);
        repeat (10) tick();
        baud_div = 16'd8;
      end
      begin
        tick();
        expect_frame(8'h69, 4, 1'b0, 1'b0, 1'b0);
        expect_frame(8'hB4, 8, 1'b0, 1'b0, 1'b0);
      end
    join
    expect_idle_after();

    // Reset mid-frame with three words queued
    baud_div = 16'd4;
    words[0] = 8'h00; words[1] = 8'h11; words[2] = 8'h22; words[3] = 8'h33;
    for (int i = 0; i < 4; i++) begin
      s_data  = words[i];
      s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    chk("queued_before_reset", {29'd0, fifo_count}, 32'd3);
    repeat (4) tick();
    chk("tx_low_in_data", {31'd0, tx}, 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_tx", {31'd0, tx}, 32'd1);
    chk("async_rst_count", {29'd0, fifo_count}, 32'd0);
    chk("async_rst_busy", {31'd0, tx_busy}, 32'd0);
    repeat (3) tick();
    rstn = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    chk("post_rst_tx_low_seen", {31'd0, saw_low}, 32'd0);
    chk("post_rst_busy", {31'd0, tx_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
